// File: rtl/cabac_de_intra_luma_mode_if.sv
// Syntax-element input and decoded-mode output handshakes of the intra luma
// mode decoder. The slave modport is the decoder's view of the bus.
interface cabac_de_intra_luma_mode_if #(
  parameter int MODE_W = 6
);
  logic              se_valid_i;
  logic              se_ready_o;
  logic              se_flag_i;
  logic [1:0]        se_mpm_idx_i;
  logic [4:0]        se_rem_mode_i;
  logic              mode_valid_o;
  logic              mode_ready_i;
  logic [MODE_W-1:0] mode_o;
  logic [1:0]        mode_pu_idx_o;

  modport master (
    output se_valid_i, se_flag_i, se_mpm_idx_i, se_rem_mode_i, mode_ready_i,
    input  se_ready_o, mode_valid_o, mode_o, mode_pu_idx_o
  );

  modport slave (
    input  se_valid_i, se_flag_i, se_mpm_idx_i, se_rem_mode_i, mode_ready_i,
    output se_ready_o, mode_valid_o, mode_o, mode_pu_idx_o
  );
endinterface

// File: rtl/cabac_de_intra_luma_mode.sv
// Decoder-side intra luma mode reconstruction. For each PU of an intra CU
// (1 PU for 2Nx2N, 4 PUs in z-order for NxN) it takes the parsed
// prev_intra_luma_pred_flag / mpm_idx / rem_intra_luma_pred_mode, builds the
// 3-entry MPM list from left/top neighbours and emits the 0..34 luma mode.
// Later NxN PUs take earlier PUs' decoded modes as neighbours.
module cabac_de_intra_luma_mode #(
  parameter int MODE_W = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic                          part_nxn_i,
  input  logic [MODE_W-1:0]             left_mode_0_i,
  input  logic [MODE_W-1:0]             left_mode_1_i,
  input  logic [MODE_W-1:0]             top_mode_0_i,
  input  logic [MODE_W-1:0]             top_mode_1_i,
  cabac_de_intra_luma_mode_if.slave     io,
  output logic                          busy_o,
  output logic                          done_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SE     = 2'd1,
    DERIVE = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam logic [MODE_W-1:0] MODE_PLANAR = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_DC     = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_VER    = MODE_W'(26);

  state_t            state, state_nxt;

  logic              part_nxn_q;
  logic [MODE_W-1:0] left_q0, left_q1, top_q0, top_q1;
  logic [1:0]        pu_idx;
  logic              flag_q;
  logic [1:0]        mpm_q;
  logic [4:0]        rem_q;
  logic [MODE_W-1:0] pu_mode [0:3];
  logic [MODE_W-1:0] mode_q;
  logic              done_q;

  logic              se_hs, mode_hs, last_pu;
  logic [MODE_W-1:0] nb_l, nb_t;
  logic [MODE_W-1:0] c0, c1, c2;
  logic [MODE_W-1:0] s0, s1, s2, sw;
  logic [MODE_W-1:0] mode_dec;

  assign se_hs   = (state == SE)  && io.se_valid_i;
  assign mode_hs = (state == OUT) && io.mode_ready_i;
  assign last_pu = (pu_idx == (part_nxn_q ? 2'd3 : 2'd0));

  assign io.se_ready_o    = (state == SE);
  assign io.mode_valid_o  = (state == OUT);
  assign io.mode_o        = mode_q;
  assign io.mode_pu_idx_o = pu_idx;
  assign busy_o           = (state != IDLE);
  assign done_o           = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE -> SE -> DERIVE -> OUT -> (SE | IDLE).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = SE;
      SE:      if (se_hs)   state_nxt = DERIVE;
      DERIVE:               state_nxt = OUT;
      OUT:     if (mode_hs) state_nxt = last_pu ? IDLE : SE;
      default:              state_nxt = IDLE;
    endcase
  end

  // CU context, syntax-element capture, decoded-mode storage and PU sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      part_nxn_q <= 1'b0;
      left_q0    <= MODE_DC;
      left_q1    <= MODE_DC;
      top_q0     <= MODE_DC;
      top_q1     <= MODE_DC;
      pu_idx     <= '0;
      flag_q     <= 1'b0;
      mpm_q      <= '0;
      rem_q      <= '0;
      mode_q     <= '0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) pu_mode[i] <= MODE_DC;
    end else begin
      done_q <= mode_hs && last_pu;
      if (state == IDLE && start_i) begin
        part_nxn_q <= part_nxn_i;
        left_q0    <= left_mode_0_i;
        left_q1    <= left_mode_1_i;
        top_q0     <= top_mode_0_i;
        top_q1     <= top_mode_1_i;
        pu_idx     <= '0;
      end
      if (se_hs) begin
        flag_q <= io.se_flag_i;
        mpm_q  <= io.se_mpm_idx_i;
        rem_q  <= io.se_rem_mode_i;
      end
      if (state == DERIVE) begin
        mode_q          <= mode_dec;
        pu_mode[pu_idx] <= mode_dec;
      end
      if (mode_hs && !last_pu) pu_idx <= pu_idx + 2'd1;
    end
  end

  // Neighbour selection: inside an NxN CU, PUs to the right of / below an
  // earlier PU use that PU's decoded mode instead of the CU-level neighbour.
  always_comb begin
    nb_l = left_q0;
    nb_t = top_q0;
    case (pu_idx)
      2'd0: begin nb_l = left_q0;    nb_t = top_q0;     end
      2'd1: begin nb_l = pu_mode[0]; nb_t = top_q1;     end
      2'd2: begin nb_l = left_q1;    nb_t = pu_mode[0]; end
      default: begin nb_l = pu_mode[2]; nb_t = pu_mode[1]; end
    endcase
  end

  // Three-entry most-probable-mode candidate list.
  always_comb begin
    c0 = nb_l;
    c1 = nb_t;
    c2 = MODE_PLANAR;
    if (nb_l == nb_t) begin
      if (nb_l >= MODE_W'(2)) begin
        c0 = nb_l;
        c1 = ((nb_l + MODE_W'(29)) & MODE_W'(31)) + MODE_W'(2);
        c2 = ((nb_l - MODE_W'(1))  & MODE_W'(31)) + MODE_W'(2);
      end else begin
        c0 = MODE_PLANAR;
        c1 = MODE_DC;
        c2 = MODE_VER;
      end
    end else if (nb_l != '0 && nb_t != '0) begin
      c2 = MODE_PLANAR;
    end else begin
      c2 = ((nb_l + nb_t) < MODE_W'(2)) ? MODE_VER : MODE_DC;
    end
  end

  // Ascending sort of the candidates (three compare-exchange steps).
  always_comb begin
    s0 = c0;
    s1 = c1;
    s2 = c2;
    sw = '0;
    if (s0 > s1) begin sw = s0; s0 = s1; s1 = sw; end
    if (s1 > s2) begin sw = s1; s1 = s2; s2 = sw; end
    if (s0 > s1) begin sw = s0; s0 = s1; s1 = sw; end
  end

  // Mode reconstruction: MPM pick, or remaining mode stepped past each
  // sorted candidate it reaches; an out-of-range mpm_idx falls back to DC.
  always_comb begin
    mode_dec = MODE_W'(rem_q);
    if (flag_q) begin
      case (mpm_q)
        2'd0:    mode_dec = c0;
        2'd1:    mode_dec = c1;
        2'd2:    mode_dec = c2;
        default: mode_dec = MODE_DC;
      endcase
    end else begin
      if (mode_dec >= s0) mode_dec = mode_dec + MODE_W'(1);
      if (mode_dec >= s1) mode_dec = mode_dec + MODE_W'(1);
      if (mode_dec >= s2) mode_dec = mode_dec + MODE_W'(1);
    end
  end

endmodule

// File: doc/cabac_de_intra_luma_mode.md
Name: cabac_de_intra_luma_mode

Overview:
- Decoder-side counterpart of the intra luma syntax-element prepare stage.
- Takes parsed prev_intra_luma_pred_flag, mpm_idx and rem_intra_luma_pred_mode for each luma PU of one intra CU, and rebuilds the 6-bit luma prediction mode (0..34) using the HEVC 3-candidate MPM list.
- Handles 2Nx2N (1 PU) and NxN (4 PUs, z-order); later PUs use earlier PUs' decoded modes as neighbours.
- Sits between the CABAC bin parser and intra prediction / chroma-mode derivation.

Parameters:
- MODE_W, 6, width of a luma mode value.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start_i  input  1  CU start pulse; accepted only in IDLE
- part_nxn_i  input  1  1 = NxN (4 PUs), 0 = 2Nx2N (1 PU); sampled with start_i
- left_mode_0_i  input  6  left neighbour mode for PU row 0; sampled with start_i
- left_mode_1_i  input  6  left neighbour mode for PU row 1; sampled with start_i
- top_mode_0_i  input  6  top neighbour mode for PU column 0; sampled with start_i
- top_mode_1_i  input  6  top neighbour mode for PU column 1; sampled with start_i
- se_valid_i  input  1  syntax elements for current PU valid
- se_ready_o  output  1  block accepts syntax elements
- se_flag_i  input  1  prev_intra_luma_pred_flag
- se_mpm_idx_i  input  2  mpm_idx (0..2), used when flag=1
- se_rem_mode_i  input  5  rem_intra_luma_pred_mode (0..31), used when flag=0
- mode_valid_o  output  1  decoded mode valid
- mode_ready_i  input  1  consumer accepts mode
- mode_o  output  6  decoded luma mode
- mode_pu_idx_o  output  2  PU index (0..3) of mode_o
- busy_o  output  1  high whenever state != IDLE
- done_o  output  1  one-cycle pulse after the last PU's mode handshake

Behaviour:
- Neighbour inputs arrive already substituted: unavailable, non-intra or above-CTU neighbours are given as DC (1).
- FSM states:
  - IDLE: start_i latches part and neighbours, clears pu_idx, goes to SE.
  - SE: se_ready_o=1; se_valid_i&&se_ready_o registers flag/idx/rem, goes to DERIVE.
  - DERIVE: one cycle; builds candidates, computes mode, writes mode_o and pu_mode[pu_idx], goes to OUT.
  - OUT: mode_valid_o=1, outputs held stable until mode_ready_i. On handshake, last PU (idx 0 for 2Nx2N, 3 for NxN) goes to IDLE with done_o=1 in the next cycle; otherwise pu_idx++ and back to SE.
- Latency: SE handshake at cycle t gives mode_valid_o high at t+2. Back-to-back PUs take 3 cycles each at minimum.
- Neighbours (L, T) per PU:
  - PU0: L=left_0, T=top_0
  - PU1: L=pu_mode[0], T=top_1
  - PU2: L=left_1, T=pu_mode[0]
  - PU3: L=pu_mode[2], T=pu_mode[1]
- Candidates (c0, c1, c2):
  - L==T, L>=2: {L, ((L+29)&31)+2, ((L-1)&31)+2}.
  - L==T, L<2: {0, 1, 26}.
  - L!=T, both nonzero: {L, T, 0}.
  - L!=T, otherwise: {L, T, (L+T<2) ? 26 : 1}.
- Decoding:
  - flag=1: mode = c[mpm_idx]. mpm_idx=3 is illegal; output 1 (DC).
  - flag=0: sort candidates ascending s0<=s1<=s2. m=rem; then in order: if m>=s0 then m++; if m>=s1 then m++; if m>=s2 then m++. All arithmetic is 6-bit, result 0..34.
- Reset values: state IDLE, se_ready_o=0, mode_valid_o=0, mode_o=0, mode_pu_idx_o=0, busy_o=0, done_o=0, pu_mode[*]=1.
- Boundary conditions:
  - start_i outside IDLE is ignored.
  - se_valid_i outside SE is ignored, with no side effects.
  - start_i in the same cycle as done_o is accepted, since state is already IDLE.
  - rst mid-CU aborts to IDLE with no done_o and drops any pending mode.
  - Inputs changing during OUT do not affect mode_o.

Test Plan:
- 2Nx2N, L=T=26, flag=1 mpm=1 -> candidates {26,25,27}, mode_o=25, pu_idx 0, valid 2 cycles after SE handshake, done_o pulse.
- 2Nx2N, L=T=1, flag=0 rem=0 -> sorted {0,1,26}, mode_o=2; repeat with rem=31 -> mode_o=34.
- 2Nx2N, L=10 T=0, flag=0 rem=5 -> candidates {10,0,1}, mode_o=7; rem=30 -> mode_o=33.
- NxN, all neighbours 1, in order:
  - PU0 flag1 mpm2 -> 26.
  - PU1 (L=26, T=1) flag0 rem0 -> 2.
  - PU2 (L=1, T=26) flag1 mpm0 -> 1.
  - PU3 (L=1, T=2) flag1 mpm1 -> 2.
  - pu_idx 0..3; done_o only after the PU3 handshake.
- Backpressure: hold mode_ready_i low 3 cycles in OUT -> mode_o/mode_pu_idx_o stable, se_ready_o=0, second se_valid_i ignored; the PU then proceeds normally.
- Reset while in OUT of NxN PU1 -> next cycle all outputs at reset values; new start_i decodes correctly from PU0.
